// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch: FSM states, packed BCD time and the
// one-hundredth increment with digit carries and minute wrap.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
    logic [3:0] hun_t;
    logic [3:0] hun_o;
  } bcd_time_t;

  typedef struct packed {
    logic      wrap;
    bcd_time_t tval;
  } bcd_inc_t;

  localparam logic [3:0] DIGIT_MAX       = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX    = 4'd5;
  localparam int         DEFAULT_MAX_MIN = 59;

  function automatic bcd_inc_t bcd_increment(input bcd_time_t t,
                                             input logic [3:0] min_t_max,
                                             input logic [3:0] min_o_max);
    bcd_inc_t r;
    logic     carry;
    r.tval = t;
    r.wrap = 1'b0;
    carry  = 1'b1;
    if (t.hun_o == DIGIT_MAX) r.tval.hun_o = '0;
    else begin r.tval.hun_o = t.hun_o + 4'd1; carry = 1'b0; end
    if (carry) begin
      if (t.hun_t == DIGIT_MAX) r.tval.hun_t = '0;
      else begin r.tval.hun_t = t.hun_t + 4'd1; carry = 1'b0; end
    end
    if (carry) begin
      if (t.sec_o == DIGIT_MAX) r.tval.sec_o = '0;
      else begin r.tval.sec_o = t.sec_o + 4'd1; carry = 1'b0; end
    end
    if (carry) begin
      if (t.sec_t == SEC_TENS_MAX) r.tval.sec_t = '0;
      else begin r.tval.sec_t = t.sec_t + 4'd1; carry = 1'b0; end
    end
    // Minutes wrap at the configured ceiling rather than at 99.
    if (carry) begin
      if (t.min_t == min_t_max && t.min_o == min_o_max) begin
        r.tval.min_t = '0;
        r.tval.min_o = '0;
        r.wrap       = 1'b1;
      end else if (t.min_o == DIGIT_MAX) begin
        r.tval.min_o = '0;
        r.tval.min_t = t.min_t + 4'd1;
      end else begin
        r.tval.min_o = t.min_o + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Control pulses in, status and BCD display out, for the stopwatch block.
interface stopwatch_ctrl_if;
  logic        start_stop_i;
  logic        clear_i;
  logic        lap_i;
  logic        running_o;
  logic        lap_active_o;
  logic        tick_o;
  logic        overflow_o;
  logic [23:0] disp_bcd_o;

  modport master (
    output start_stop_i, clear_i, lap_i,
    input  running_o, lap_active_o, tick_o, overflow_o, disp_bcd_o
  );

  modport slave (
    input  start_stop_i, clear_i, lap_i,
    output running_o, lap_active_o, tick_o, overflow_o, disp_bcd_o
  );
endinterface

// File: rtl/tick_prescaler.sv
// Clock-enable prescaler: counts 0..TICK_DIV-1 while enabled, holds otherwise,
// and strobes on the terminal count of the current (pre-edge) value.
module tick_prescaler #(
  parameter int TICK_DIV = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_terminal
);
  localparam int             W    = $clog2(TICK_DIV);
  localparam logic [W-1:0]   LAST = W'(TICK_DIV - 1);

  logic [W-1:0] r_count;
  logic         w_at_last;

  assign w_at_last  = (r_count == LAST);
  assign o_terminal = i_enable && w_at_last && !i_clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_count <= '0;
    else if (i_clear)  r_count <= '0;
    else if (i_enable) r_count <= w_at_last ? '0 : r_count + W'(1);
  end
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: IDLE/RUN/PAUSE FSM, BCD mm:ss.hh chain and display mux.
// Lap freeze is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 1000000,
  parameter int MAX_MIN  = DEFAULT_MAX_MIN
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_ctrl_if.slave  sw
);
  localparam logic [3:0] MIN_T_MAX = 4'(MAX_MIN / 10);
  localparam logic [3:0] MIN_O_MAX = 4'(MAX_MIN % 10);

  state_e    r_state, w_state_next;
  bcd_time_t r_time, w_time_next;
  bcd_time_t r_disp, w_disp_next;
  bcd_inc_t  w_inc;
  logic      r_tick, r_overflow, w_overflow_next, r_running;
  logic      w_terminal;
  logic      w_lap_active_q;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .i_enable   (r_state == ST_RUN),
    .i_clear    (sw.clear_i),
    .o_terminal (w_terminal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next    = r_state;
    w_time_next     = r_time;
    w_overflow_next = r_overflow;
    w_inc           = bcd_increment(r_time, MIN_T_MAX, MIN_O_MAX);
    if (sw.clear_i) begin
      w_state_next    = ST_IDLE;
      w_time_next     = '0;
      w_overflow_next = 1'b0;
    end else begin
      // The tick is judged on the pre-edge state, so a pause on the
      // terminal edge still counts that hundredth.
      if (w_terminal) begin
        w_time_next     = w_inc.tval;
        w_overflow_next = r_overflow | w_inc.wrap;
      end
      if (sw.start_stop_i) begin
        case (r_state)
          ST_IDLE:  w_state_next = ST_RUN;
          ST_RUN:   w_state_next = ST_PAUSE;
          ST_PAUSE: w_state_next = ST_RUN;
          default:  w_state_next = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_time     <= '0;
      r_disp     <= '0;
      r_tick     <= 1'b0;
      r_overflow <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_time     <= w_time_next;
      r_disp     <= w_disp_next;
      r_tick     <= w_terminal;
      r_overflow <= w_overflow_next;
      r_running  <= (w_state_next == ST_RUN);
    end
  end

`ifdef STOPWATCH_LAP_EN
  bcd_time_t r_lap, w_lap_next;
  logic      r_lap_active, w_lap_active_next;
  logic      w_lap_toggle;

  // Lap loses to both clear and start_stop arriving in the same cycle.
  assign w_lap_toggle = sw.lap_i && !sw.clear_i && !sw.start_stop_i &&
                        (r_state != ST_IDLE);

  always_comb begin
    w_lap_next        = r_lap;
    w_lap_active_next = r_lap_active;
    if (sw.clear_i) begin
      w_lap_next        = '0;
      w_lap_active_next = 1'b0;
    end else if (w_lap_toggle) begin
      w_lap_active_next = !r_lap_active;
      if (!r_lap_active) w_lap_next = r_time;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lap        <= '0;
      r_lap_active <= 1'b0;
    end else begin
      r_lap        <= w_lap_next;
      r_lap_active <= w_lap_active_next;
    end
  end

  assign w_disp_next    = w_lap_active_next ? w_lap_next : w_time_next;
  assign w_lap_active_q = r_lap_active;
`else
  assign w_disp_next    = w_time_next;
  assign w_lap_active_q = 1'b0;
`endif

  assign sw.running_o    = r_running;
  assign sw.lap_active_o = w_lap_active_q;
  assign sw.tick_o       = r_tick;
  assign sw.overflow_o   = r_overflow;
  assign sw.disp_bcd_o   = r_disp;
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

- Sequences the 100 Hz hundredth-second timebase for the terminal's stopwatch feature: start, pause, resume, clear and lap-freeze.
- Accumulates elapsed time as packed BCD mm:ss.hh and drives the display/formatter path.
- Replaces the free-running derived-clock divider with a single-domain clock-enable tick, so all logic stays on `clk`.

## Interface
Parameters:
- `TICK_DIV`, default 1000000: `clk` cycles per hundredth (100 MHz → 100 Hz); must be ≥ 2.
- `MAX_MIN`, default 59: highest minute value before wrap to 00:00.00.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `start_stop_i`  in  1  one-cycle pulse (debounced upstream); toggles run/pause.
- `clear_i`  in  1  one-cycle pulse; zeroes time and returns to IDLE.
- `lap_i`  in  1  one-cycle pulse; toggles lap freeze.
- `running_o`  out  1  high in RUN.
- `lap_active_o`  out  1  display frozen at lap capture.
- `tick_o`  out  1  one-cycle pulse per counted hundredth.
- `overflow_o`  out  1  sticky; set on wrap past MAX_MIN:59.99.
- `disp_bcd_o`  out  24  {min_t, min_o, sec_t, sec_o, hun_t, hun_o}, 4 bits each.

## Operation
FSM states are IDLE, RUN and PAUSE.
- IDLE + start_stop → RUN.
- RUN + start_stop → PAUSE.
- PAUSE + start_stop → RUN.
- clear_i from any state → IDLE, with time, lap register, prescaler, lap_active and overflow all zeroed.

Priority in a single cycle: clear > start_stop > lap. When start_stop and lap arrive together, lap is dropped.

Prescaler:
- Counts 0..TICK_DIV-1 only in RUN.
- Holds its value in PAUSE, so the partial hundredth is kept on resume.
- Zeroed only by clear or reset.

Time update:
- On the edge where the prescaler equals TICK_DIV-1 in RUN, the prescaler goes to 0 and the time increments by one hundredth.
- Increment rules: hun 99→00 carries into sec; sec 59→00 carries into min; MAX_MIN:59.99 → 00:00.00 and sets overflow_o.
- Each BCD digit is held in 0–9 (tens of seconds 0–5); no illegal digit value is ever produced.

Lap:
- In RUN or PAUSE, lap_i toggles lap_active_o.
- On a 0→1 toggle, the live time is captured into the lap register. When the capture edge is also a tick edge, the pre-increment value is captured.
- In IDLE, lap_i is ignored.

Display:
- disp_bcd_o shows the lap register while lap_active_o=1, otherwise the live time.
- Live time keeps counting while frozen.

## Timing
- All outputs are registered.
- Reset values: running_o=0, lap_active_o=0, tick_o=0, overflow_o=0, disp_bcd_o=0, state=IDLE.
- Control pulse on edge N → state, running_o and lap_active_o are valid after edge N.
- Time and tick latency:
  - tick_o is high for exactly the one cycle following the incrementing edge.
  - disp_bcd_o reflects the new time in that same cycle.
- First tick after IDLE→RUN on edge N occurs on edge N+TICK_DIV.
- A start_stop pulse on the same edge as the terminal prescaler count: the transition takes effect and that tick is still counted when leaving RUN. The count is evaluated against the pre-edge state.
- Reset asserted mid-count: all outputs drop to their reset values immediately (asynchronously), and no tick_o glitch is permitted.
- overflow_o stays set through further wraps until clear or reset.

## Configuration
- `STOPWATCH_LAP_EN` defined: the lap register, lap_i handling and lap_active_o are implemented as above.
- `STOPWATCH_LAP_EN` undefined:
  - lap_i is ignored.
  - lap_active_o is tied 0.
  - disp_bcd_o always shows live time.
  - No lap register is synthesized.
  - All other behaviour is unchanged.

## Structure
The shared package `stopwatch_pkg` holds:
- the state enum (IDLE/RUN/PAUSE);
- the packed BCD time typedef (six 4-bit digits);
- digit-limit constants (9, 5, MAX_MIN).

Sub-module `tick_prescaler`:
- Inputs: enable and clear.
- Output: a one-cycle terminal-count strobe.
- Parameterised by TICK_DIV.
- Width is $clog2(TICK_DIV).

The BCD chain and FSM stay in `stopwatch_ctrl`.

## Test plan
All scenarios use TICK_DIV=4, MAX_MIN=59, with the lap macro defined unless stated otherwise.
1. Reset, start_stop pulse, run 400 cycles → disp_bcd_o = 00:01.00, 100 tick_o pulses, running_o=1.
2. Start, then pause after 10 cycles, wait 50, resume → first post-resume tick at 2 cycles (prescaler held at 2); total hundredths = elapsed RUN cycles / 4.
3. Preload 59:59.98 through run time, then 2 ticks → 00:00.00, overflow_o=1; clear → overflow_o=0, IDLE.
4. Lap at 00:00.05, run 20 more ticks → disp_bcd_o stays 00:00.05; lap again → shows 00:00.25.
5. clear_i, start_stop_i and lap_i in the same cycle during RUN → IDLE, all zero, lap_active_o=0. Then start_stop_i and lap_i together in IDLE → RUN, lap_active_o=0.
6. Assert rst mid-count in RUN with lap active → all outputs 0 asynchronously. Build without STOPWATCH_LAP_EN: lap_i has no effect.
